// File: rtl/f_pcctrl.sv
// Fetch-stage PC controller.
// Owns the PC, drives the single-outstanding instruction-memory request,
// turns redirect requests into PC-mux select codes and loads the IF/ID
// instruction register, holding it across hazard stalls and squashing
// wrong-path fetches.
//
// Memory handshake: o_imem_req is the request valid and i_imem_ack is the
// completion. A request, once raised, keeps o_imem_addr stable until the cycle
// in which i_imem_ack=1. i_imem_rdata is only sampled in that cycle. At most one
// request is outstanding.
module f_pcctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_con_stall,
   input  logic [1:0]  i_req_jump,
   input  logic        i_req_branch,
   input  logic [31:0] i_addr_nextpc,
   output logic [31:0] o_addr_pcplus4,
   output logic [1:0]  o_con_jump,
   output logic        o_con_ifbranch,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_inst,
   output logic        o_inst_valid,
   output logic [31:0] o_addr_pc_id
);

   // RST: idle after reset. FETCH: live request. HOLD: fetched word parked in
   // the skid buffer while ID is stalled. DROP: waiting out a wrong-path request.
   typedef enum logic [1:0] {
      ST_RST   = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DROP  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] faddr_q, faddr_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] inst_q, inst_d;
   logic        inst_valid_q, inst_valid_d;
   logic [31:0] pc_id_q, pc_id_d;

   logic        jump_req;
   logic        redirect;

   // Redirects only count while ID is not stalled; the EX branch is older and
   // therefore beats the ID jump.
   assign jump_req       = (i_req_jump == 2'b01) || (i_req_jump == 2'b10);
   assign redirect       = !i_con_stall && (i_req_branch || jump_req);
   assign o_con_ifbranch = !i_con_stall && i_req_branch;
   assign o_con_jump     = (!i_con_stall && !i_req_branch && jump_req) ? i_req_jump : 2'b00;

   assign o_addr_pcplus4 = pc_q + 32'd4;
   assign o_imem_req     = (state_q == ST_FETCH) || (state_q == ST_DROP);
   assign o_imem_addr    = faddr_q;
   assign o_inst         = inst_q;
   assign o_inst_valid   = inst_valid_q;
   assign o_addr_pc_id   = pc_id_q;

   // Next-state and register-update logic for the fetch sequencer.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      faddr_d      = faddr_q;
      skid_inst_d  = skid_inst_q;
      skid_pc_d    = skid_pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      pc_id_d      = pc_id_q;
      case (state_q)
         ST_RST: begin
            state_d = ST_FETCH;
            faddr_d = pc_q;
         end
         ST_FETCH: begin
            if (redirect) begin
               // Any returned word is wrong-path. Without an ack the old
               // request must still complete, so its address is kept.
               pc_d         = i_addr_nextpc;
               inst_valid_d = 1'b0;
               if (i_imem_ack) begin
                  faddr_d = i_addr_nextpc;
               end else begin
                  state_d = ST_DROP;
               end
            end else if (i_imem_ack) begin
               if (i_con_stall) begin
                  skid_inst_d = i_imem_rdata;
                  skid_pc_d   = pc_q;
                  state_d     = ST_HOLD;
               end else begin
                  inst_d       = i_imem_rdata;
                  pc_id_d      = pc_q;
                  inst_valid_d = 1'b1;
                  pc_d         = i_addr_nextpc;
                  faddr_d      = i_addr_nextpc;
               end
            end else if (!i_con_stall) begin
               inst_valid_d = 1'b0;
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_d         = i_addr_nextpc;
               faddr_d      = i_addr_nextpc;
               inst_valid_d = 1'b0;
               state_d      = ST_FETCH;
            end else if (!i_con_stall) begin
               inst_d       = skid_inst_q;
               pc_id_d      = skid_pc_q;
               inst_valid_d = 1'b1;
               pc_d         = i_addr_nextpc;
               faddr_d      = i_addr_nextpc;
               state_d      = ST_FETCH;
            end
         end
         ST_DROP: begin
            inst_valid_d = 1'b0;
            if (redirect) begin
               pc_d = i_addr_nextpc;
            end
            if (i_imem_ack) begin
               // The newest redirect target wins if it arrives with the ack.
               faddr_d = redirect ? i_addr_nextpc : pc_q;
               state_d = ST_FETCH;
            end
         end
         default: begin
            state_d = ST_RST;
         end
      endcase
   end

   // State and datapath registers, cleared asynchronously.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_RST;
         pc_q         <= RESET_PC;
         faddr_q      <= RESET_PC;
         skid_inst_q  <= 32'd0;
         skid_pc_q    <= 32'd0;
         inst_q       <= 32'd0;
         inst_valid_q <= 1'b0;
         pc_id_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         faddr_q      <= faddr_d;
         skid_inst_q  <= skid_inst_d;
         skid_pc_q    <= skid_pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         pc_id_q      <= pc_id_d;
      end
   end

endmodule

// File: tb/tb_f_pcctrl.sv
// Bench for f_pcctrl: directed fetch scenarios followed by randomized traffic,
// every cycle compared with a transaction-level model of the fetch stage.
module tb_f_pcctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_con_stall;
   logic [1:0]  i_req_jump;
   logic        i_req_branch;
   logic [31:0] i_addr_nextpc;
   logic [31:0] o_addr_pcplus4;
   logic [1:0]  o_con_jump;
   logic        o_con_ifbranch;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;
   logic [31:0] o_inst;
   logic        o_inst_valid;
   logic [31:0] o_addr_pc_id;

   logic [31:0] br_tgt;
   logic [31:0] jmp_tgt;

   int n_vec = 0;
   int n_err = 0;

   // model state: architectural pc, address of the live request, IF/ID contents,
   // whether fetching has begun, whether the live request is wrong-path, and
   // the instruction parked during a stall
   logic [31:0] m_pc, m_faddr, m_inst, m_pc_id;
   logic        m_valid, m_live, m_discard;
   logic [63:0] m_held[$];

   always #5 clk = ~clk;

   f_pcctrl #(.RESET_PC(32'h0000_0000)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_con_stall    (i_con_stall),
      .i_req_jump     (i_req_jump),
      .i_req_branch   (i_req_branch),
      .i_addr_nextpc  (i_addr_nextpc),
      .o_addr_pcplus4 (o_addr_pcplus4),
      .o_con_jump     (o_con_jump),
      .o_con_ifbranch (o_con_ifbranch),
      .o_imem_req     (o_imem_req),
      .o_imem_addr    (o_imem_addr),
      .i_imem_ack     (i_imem_ack),
      .i_imem_rdata   (i_imem_rdata),
      .o_inst         (o_inst),
      .o_inst_valid   (o_inst_valid),
      .o_addr_pc_id   (o_addr_pc_id)
   );

   // external PC-select mux
   always_comb begin
      if (o_con_ifbranch) i_addr_nextpc = br_tgt;
      else if (o_con_jump != 2'b00) i_addr_nextpc = jmp_tgt;
      else i_addr_nextpc = o_addr_pcplus4;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'h0000_0000;
      m_faddr   = 32'h0000_0000;
      m_inst    = 32'd0;
      m_pc_id   = 32'd0;
      m_valid   = 1'b0;
      m_live    = 1'b0;
      m_discard = 1'b0;
      m_held.delete();
   endtask

   task automatic check_outputs();
      logic       exp_req;
      logic       exp_br;
      logic [1:0] exp_j;
      exp_req = m_live && (m_held.size() == 0);
      exp_br  = !i_con_stall && i_req_branch;
      exp_j   = (!i_con_stall && !i_req_branch && (i_req_jump == 2'b01 || i_req_jump == 2'b10))
                ? i_req_jump : 2'b00;
      check_eq("imem_req", 32'(o_imem_req), 32'(exp_req));
      if (exp_req) check_eq("imem_addr", o_imem_addr, m_faddr);
      check_eq("pcplus4", o_addr_pcplus4, m_pc + 32'd4);
      check_eq("inst_valid", 32'(o_inst_valid), 32'(m_valid));
      check_eq("inst", o_inst, m_inst);
      check_eq("pc_id", o_addr_pc_id, m_pc_id);
      check_eq("con_ifbranch", 32'(o_con_ifbranch), 32'(exp_br));
      check_eq("con_jump", 32'(o_con_jump), 32'(exp_j));
   endtask

   // advance the model by one clock using the inputs applied this cycle
   task automatic model_update();
      logic        redir;
      logic [31:0] tgt;
      redir = !i_con_stall && (i_req_branch || i_req_jump == 2'b01 || i_req_jump == 2'b10);
      tgt   = i_req_branch ? br_tgt : jmp_tgt;
      if (!m_live) begin
         m_live  = 1'b1;
         m_faddr = m_pc;
      end else if (m_held.size() != 0) begin
         if (redir) begin
            m_held.delete();
            m_pc    = tgt;
            m_faddr = tgt;
            m_valid = 1'b0;
         end else if (!i_con_stall) begin
            {m_inst, m_pc_id} = m_held.pop_front();
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_faddr = m_pc;
         end
      end else if (m_discard) begin
         m_valid = 1'b0;
         if (redir) m_pc = tgt;
         if (i_imem_ack) begin
            m_faddr   = m_pc;
            m_discard = 1'b0;
         end
      end else if (redir) begin
         m_pc    = tgt;
         m_valid = 1'b0;
         if (i_imem_ack) m_faddr = tgt;
         else m_discard = 1'b1;
      end else if (i_imem_ack) begin
         if (i_con_stall) begin
            m_held.push_back({i_imem_rdata, m_pc});
         end else begin
            m_inst  = i_imem_rdata;
            m_pc_id = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_faddr = m_pc;
         end
      end else if (!i_con_stall) begin
         m_valid = 1'b0;
      end
   endtask

   // one clock: drive on the falling edge, check, then clock the model
   task automatic step(input logic stall, input logic [1:0] jump, input logic br,
                       input logic ack, input logic [31:0] bt, input logic [31:0] jt);
      @(negedge clk);
      i_con_stall  = stall;
      i_req_jump   = jump;
      i_req_branch = br;
      i_imem_ack   = ack;
      i_imem_rdata = $urandom;
      br_tgt       = bt;
      jmp_tgt      = jt;
      #1;
      check_outputs();
      @(posedge clk);
      model_update();
   endtask

   // asynchronous reset in the middle of a cycle, released away from the edge
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      check_eq("rst_imem_addr", o_imem_addr, 32'h0000_0000);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      i_con_stall  = 1'b0;
      i_req_jump   = 2'b00;
      i_req_branch = 1'b0;
      i_imem_ack   = 1'b0;
      i_imem_rdata = 32'd0;
      br_tgt       = 32'd0;
      jmp_tgt      = 32'd0;
      rst_n        = 1'b1;
      model_reset();
      do_reset();

      // straight-line fetch; stray ack in the RST cycle must be ignored
      repeat (3) step(1'b0, 2'b00, 1'b0, 1'b1, 32'd0, 32'd0);
      // j to 0x100 together with the ack for 0x8
      step(1'b0, 2'b01, 1'b0, 1'b1, 32'd0, 32'h0000_0100);
      #1 check_eq("jump_target_fetch", o_imem_addr, 32'h0000_0100);
      step(1'b0, 2'b00, 1'b0, 1'b1, 32'd0, 32'd0);
      // branch beats jr in the same cycle
      step(1'b0, 2'b10, 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0300);
      #1 check_eq("branch_wins_fetch", o_imem_addr, 32'h0000_0200);
      // three-cycle stall, ack only in the first
      step(1'b1, 2'b00, 1'b0, 1'b1, 32'd0, 32'd0);
      step(1'b1, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b1, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 2'b00, 1'b0, 1'b1, 32'd0, 32'd0);
      // redirect to 0x40 while a request waits two more cycles for its ack
      step(1'b0, 2'b01, 1'b0, 1'b0, 32'd0, 32'h0000_0040);
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
      step(1'b0, 2'b00, 1'b0, 1'b1, 32'd0, 32'd0);
      #1 check_eq("drop_then_target", o_imem_addr, 32'h0000_0040);
      // PC wrap at the top of the address space
      step(1'b0, 2'b01, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFC);
      step(1'b0, 2'b00, 1'b0, 1'b1, 32'd0, 32'd0);
      #1 check_eq("wrap_fetch", o_imem_addr, 32'h0000_0000);
      // reset while a fetch is in flight
      step(1'b0, 2'b00, 1'b0, 1'b0, 32'd0, 32'd0);
      do_reset();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic        st, br, ak;
         logic [1:0]  jp;
         logic [31:0] bt, jt;
         st = ($urandom_range(0, 99) < 20);
         ak = ($urandom_range(0, 99) < 60);
         br = ($urandom_range(0, 99) < 10);
         jp = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
         bt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
         jt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         step(st, jp, br, ak, bt, jt);
         if ($urandom_range(0, 499) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
